// File: rtl/pwm_breather_pkg.sv
// pwm_breather_pkg
// Shared types for the LED breather: the 2-bit phase enum and the raw phase
// encodings reported on phase_out.
package pwm_breather_pkg;

  localparam logic [1:0] PHASE_RISE    = 2'd0;
  localparam logic [1:0] PHASE_HOLD_HI = 2'd1;
  localparam logic [1:0] PHASE_FALL    = 2'd2;
  localparam logic [1:0] PHASE_HOLD_LO = 2'd3;

  typedef enum logic [1:0] {
    RISE    = PHASE_RISE,
    HOLD_HI = PHASE_HOLD_HI,
    FALL    = PHASE_FALL,
    HOLD_LO = PHASE_HOLD_LO
  } phase_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Two-flop synchronizer followed by a registered rising-edge detector.
// Turns an asynchronous slow clock (treated as data) into a one-cycle pulse,
// three clk_in edges after the input rises. Falling edges are ignored.
// Ports:
//   clk_in - sampling clock
//   rst    - synchronous active-high reset
//   din    - asynchronous input
//   pulse  - one-cycle pulse per rising edge of din
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/pwm_breather.sv
// pwm_breather
// Breathing LED driver: PWM whose duty ramps up, holds, ramps down, holds and
// repeats. The divided slow clock only paces the ramp; it is synchronized and
// edge-detected, never used as a clock.
// Ports:
//   clk_in      - system clock, all logic on its rising edge
//   rst         - synchronous active-high reset
//   slow_clk_in - divided clock from the divider (asynchronous)
//   enable      - run/freeze; low freezes the ramp and forces the LED off
//   led_out     - registered PWM output
//   duty_out    - current (un-gamma'd) duty
//   phase_out   - ramp phase encoding
// Build option: define PWM_BREATHER_GAMMA_EN to latch (duty*duty)>>PWM_BITS
// into the PWM comparator instead of duty.
//
// state   | meaning
// RISE    | duty climbs by STEP per step pulse until it saturates at MAX
// HOLD_HI | duty at MAX, counting HOLD_TICKS step pulses
// FALL    | duty drops by STEP per step pulse until it reaches 0
// HOLD_LO | duty at 0, counting HOLD_TICKS step pulses
module pwm_breather
  import pwm_breather_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                slow_clk_in,
  input  logic                enable,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty_out,
  output logic [1:0]          phase_out
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  // One extra bit on the saturation compares so duty+STEP never wraps.
  localparam logic [PWM_BITS:0]   MAX_W    = (PWM_BITS+1)'((1 << PWM_BITS) - 1);
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS+1)'(STEP);
  localparam logic [PWM_BITS-1:0] MAX_D    = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [HW-1:0]       HOLD_LIM = HW'(HOLD_TICKS);

  phase_t              state;
  phase_t              state_nxt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_nxt;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_nxt;
  logic [HW-1:0]       hold_inc;
  logic [PWM_BITS:0]   duty_up;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_lat;
  logic [PWM_BITS-1:0] lat_src;
  logic                led;
  logic                step;
  logic                advance;

  sync_edge_detect u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (slow_clk_in),
    .pulse  (step)
  );

  // Steps arriving while disabled are dropped, not queued.
  assign advance  = step & enable;
  assign duty_up  = {1'b0, duty} + STEP_W;
  assign hold_inc = hold_cnt + HW'(1);

`ifdef PWM_BREATHER_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
  assign lat_src = PWM_BITS'(duty_sq >> PWM_BITS);
`else
  assign lat_src = duty;
`endif

  // State register with its duty/hold datapath.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= RISE;
      duty     <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    hold_nxt  = hold_cnt;
    if (advance) begin
      case (state)
        RISE: begin
          if (duty_up >= MAX_W) begin
            duty_nxt  = MAX_D;
            hold_nxt  = '0;
            state_nxt = HOLD_HI;
          end else begin
            duty_nxt = duty_up[PWM_BITS-1:0];
          end
        end
        HOLD_HI: begin
          hold_nxt = hold_inc;
          if (hold_inc == HOLD_LIM) state_nxt = FALL;
        end
        FALL: begin
          if ({1'b0, duty} <= STEP_W) begin
            duty_nxt  = '0;
            hold_nxt  = '0;
            state_nxt = HOLD_LO;
          end else begin
            duty_nxt = duty - STEP_W[PWM_BITS-1:0];
          end
        end
        HOLD_LO: begin
          hold_nxt = hold_inc;
          if (hold_inc == HOLD_LIM) state_nxt = RISE;
        end
        default: state_nxt = RISE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    phase_out = state;
  end

  // PWM: period of MAX cycles; duty is sampled only at the wrap so a ramp
  // step never produces a runt or stretched pulse inside a period.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pwm_cnt  <= '0;
      duty_lat <= '0;
      led      <= 1'b0;
    end else if (!enable) begin
      pwm_cnt <= '0;
      led     <= 1'b0;
    end else begin
      led <= (pwm_cnt < duty_lat);
      if (pwm_cnt == CNT_LAST) begin
        pwm_cnt  <= '0;
        duty_lat <= lat_src;
      end else begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  assign led_out  = led;
  assign duty_out = duty;

endmodule

// File: tb/tb_pwm_breather.sv
module tb_pwm_breather;

  localparam int PB   = 4;
  localparam int ST   = 1;
  localparam int HT   = 2;
  localparam int MAXV = 15;

`ifdef PWM_BREATHER_GAMMA_EN
  localparam int EXP_FULL = 14;
  localparam int EXP_D5   = 1;
  localparam int EXP_D6   = 2;
`else
  localparam int EXP_FULL = 15;
  localparam int EXP_D5   = 5;
  localparam int EXP_D6   = 6;
`endif

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          slow_clk_in = 1'b0;
  logic          enable = 1'b0;
  logic          led_out;
  logic [PB-1:0] duty_out;
  logic [1:0]    phase_out;

  always #5 clk_in = ~clk_in;

  pwm_breather #(.PWM_BITS(PB), .STEP(ST), .HOLD_TICKS(HT)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .slow_clk_in (slow_clk_in),
    .enable      (enable),
    .led_out     (led_out),
    .duty_out    (duty_out),
    .phase_out   (phase_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Breathing profile: the (duty, phase) reached after each accepted step,
  // one full cycle long; index 0 is the reset point.
  int prof_duty [0:63];
  int prof_phase[0:63];
  int prof_len;

  task automatic build_profile();
    int n;
    int d;
    n = 0;
    prof_duty[n] = 0; prof_phase[n] = 0; n++;
    for (int s = 1; s * ST < MAXV; s++) begin
      prof_duty[n] = s * ST; prof_phase[n] = 0; n++;
    end
    for (int h = 0; h < HT; h++) begin
      prof_duty[n] = MAXV; prof_phase[n] = 1; n++;
    end
    prof_duty[n] = MAXV; prof_phase[n] = 2; n++;
    d = MAXV;
    while (d > ST) begin
      d = d - ST;
      prof_duty[n] = d; prof_phase[n] = 2; n++;
    end
    for (int h = 0; h < HT; h++) begin
      prof_duty[n] = 0; prof_phase[n] = 3; n++;
    end
    prof_len = n;
  endtask

  function automatic int gam(input int d);
`ifdef PWM_BREATHER_GAMMA_EN
    return (d * d) >> PB;
`else
    return d;
`endif
  endfunction

  // Reference model, advanced once per rising edge.
  int       m_pos = 0;
  int       m_cnt = 0;
  int       m_lat = 0;
  int       m_led = 0;
  bit       m_valid = 0;
  bit [3:0] hist = '0;   // hist[0] = slow_clk_in sampled at the previous edge

  always @(posedge clk_in) begin
    bit stp;
    int od;
    if (rst) begin
      m_pos = 0; m_cnt = 0; m_lat = 0; m_led = 0; hist = '0; m_valid = 1;
    end else begin
      // A rise first sampled at edge k is consumed at edge k+3.
      stp = hist[2] & ~hist[3];
      od  = prof_duty[m_pos];
      if (enable) begin
        m_led = (m_cnt < m_lat) ? 1 : 0;
        if (m_cnt == MAXV - 1) begin
          m_lat = gam(od);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
        if (stp) m_pos = (m_pos + 1) % prof_len;
      end else begin
        m_cnt = 0;
        m_led = 0;
      end
      hist = {hist[2:0], slow_clk_in};
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      check("model_led", 32'(led_out), m_led);
      check("model_duty", 32'(duty_out), prof_duty[m_pos]);
      check("model_phase", 32'(phase_out), prof_phase[m_pos]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic slow_edge(input int h, input int l);
    slow_clk_in = 1'b1;
    tick(h);
    slow_clk_in = 1'b0;
    tick(l);
  endtask

  task automatic edges(input int n);
    repeat (n) slow_edge($urandom_range(2, 4), $urandom_range(2, 4));
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick(1);
      c += int'(led_out);
    end
  endtask

  initial begin
    int c;
    int t;
    int r;
    logic prev;
    build_profile();
    rst = 1'b1; enable = 1'b1; slow_clk_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_led", 32'(led_out), 0);
    check("reset_duty", 32'(duty_out), 0);
    check("reset_phase", 32'(phase_out), 0);

    // Edge latency: duty moves on the 4th edge after the rise is sampled.
    slow_clk_in = 1'b1;
    tick(3);
    check("latency_before", 32'(duty_out), 0);
    tick(1);
    check("latency_after", 32'(duty_out), 1);
    slow_clk_in = 1'b0;
    tick(3);

    edges(14);
    check("ramp_top_duty", 32'(duty_out), 15);
    check("ramp_top_phase", 32'(phase_out), 1);
    tick(20);
    count_high(15, c);
    check("full_on_count", c, EXP_FULL);

    edges(2);
    check("hold_hi_exit", 32'(phase_out), 2);
    edges(15);
    check("fall_bottom_duty", 32'(duty_out), 0);
    check("fall_bottom_phase", 32'(phase_out), 3);
    edges(2);
    check("hold_lo_exit", 32'(phase_out), 0);

    edges(5);
    check("duty5", 32'(duty_out), 5);
    tick(20);
    count_high(15, c);
    check("duty5_count", c, EXP_D5);

    // Align to a period start, then land a step mid-period.
    t = 0;
    prev = led_out;
    tick(1);
    while (!(led_out && !prev) && t < 40) begin
      prev = led_out;
      tick(1);
      t++;
    end
    check("period_align", 32'(t < 40), 1);
    c = int'(led_out);
    slow_clk_in = 1'b1;
    for (int i = 1; i < 15; i++) begin
      tick(1);
      if (i == 3) slow_clk_in = 1'b0;
      c += int'(led_out);
    end
    check("mid_step_same_period", c, EXP_D5);
    count_high(15, c);
    check("mid_step_next_period", c, EXP_D6);
    check("duty6", 32'(duty_out), 6);

    edges(1);
    check("duty7", 32'(duty_out), 7);
    enable = 1'b0;
    tick(1);
    check("disable_led", 32'(led_out), 0);
    edges(4);
    check("disable_duty", 32'(duty_out), 7);
    check("disable_phase", 32'(phase_out), 0);
    enable = 1'b1;

    t = 0;
    while (phase_out != 2'd2 && t < 40) begin
      edges(1);
      t++;
    end
    check("reach_fall", 32'(phase_out), 2);
    edges(3);
    rst = 1'b1;
    tick(1);
    check("midfall_reset_led", 32'(led_out), 0);
    check("midfall_reset_duty", 32'(duty_out), 0);
    check("midfall_reset_phase", 32'(phase_out), 0);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        enable = ~enable;
        tick(1);
      end else if (r < 10) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end else if (r < 75) begin
        slow_edge($urandom_range(2, 5), $urandom_range(2, 5));
      end else begin
        tick($urandom_range(1, 20));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
